// File: rtl/app_loader_pkg.sv
// Purpose : shared constants for the application-core program loader peripheral.
// Latency : n/a (constants only).
// Backpr. : n/a.
package app_loader_pkg;

  // Register word offsets relative to BASE_ADDR
  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_DATA = 2'd1;
  localparam logic [1:0] REG_PTR  = 2'd2;

  // CTRL bit positions
  localparam int CTRL_LOAD_BIT = 0;
  localparam int CTRL_WRAP_BIT = 8;

  // Default application pmem word-address width
  localparam int PMEM_AW_DEF = 13;

endpackage

// File: rtl/app_loader_periph.sv
// Purpose : host-bus peripheral that streams 16-bit words into the application core's pmem.
// Latency : one pmem write strobe in the cycle after each accepted DATA write; per_dout combinational.
// Backpr. : none; one write per cycle accepted back-to-back, DATA writes dropped while LOAD=0.
//
// Ports: mclk/puc_rst (async active-high) host clock/reset; per_addr/per_din/per_en/per_we
// host peripheral bus, per_dout read data (0 when not addressed); smclk_en ignored;
// app_reset_n application reset; app_pmem_addr/dout/cen/wen application pmem write port.
// Build option: APP_LOADER_HOLD_ON_RESET_EN makes LOAD come out of reset set, keeping the
// application core in reset until the host clears LOAD.
module app_loader_periph
  import app_loader_pkg::*;
#(
  parameter logic [13:0] BASE_ADDR = 14'h0054,
  parameter int          PMEM_AW   = PMEM_AW_DEF
) (
  input  logic               mclk,
  input  logic               puc_rst,
  input  logic [13:0]        per_addr,
  input  logic [15:0]        per_din,
  input  logic               per_en,
  input  logic [1:0]         per_we,
  input  logic               smclk_en,
  output logic [15:0]        per_dout,
  output logic               app_reset_n,
  output logic [PMEM_AW-1:0] app_pmem_addr,
  output logic [15:0]        app_pmem_dout,
  output logic               app_pmem_cen,
  output logic [1:0]         app_pmem_wen
);

`ifdef APP_LOADER_HOLD_ON_RESET_EN
  localparam logic LOAD_RST = 1'b1;
`else
  localparam logic LOAD_RST = 1'b0;
`endif

  localparam logic [13:0]        CTRL_ADDR = BASE_ADDR + {12'd0, REG_CTRL};
  localparam logic [13:0]        DATA_ADDR = BASE_ADDR + {12'd0, REG_DATA};
  localparam logic [13:0]        PTR_ADDR  = BASE_ADDR + {12'd0, REG_PTR};
  localparam logic [PMEM_AW-1:0] PTR_ONE   = 1;
  localparam logic [PMEM_AW-1:0] PTR_MAX   = '1;

  logic               load;
  logic               wrap;
  logic [PMEM_AW-1:0] ptr;

  // smclk_en is part of the standard peripheral interface but has no role here
  logic unused_smclk_en;
  assign unused_smclk_en = smclk_en;

  // Address decode
  logic ctrl_hit, data_hit, ptr_hit, wr_en, rd_en;
  assign ctrl_hit = (per_addr == CTRL_ADDR);
  assign data_hit = (per_addr == DATA_ADDR);
  assign ptr_hit  = (per_addr == PTR_ADDR);
  assign wr_en    = per_en & (|per_we);
  assign rd_en    = per_en & ~(|per_we);

  // LOAD lives in the low byte, so only the low-lane enable writes it.
  // DATA and PTR writes are only honoured while loading.
  logic ctrl_wr, data_wr, ptr_wr;
  assign ctrl_wr = wr_en & ctrl_hit & per_we[0];
  assign data_wr = wr_en & data_hit & load;
  assign ptr_wr  = wr_en & ptr_hit  & load;

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      load          <= LOAD_RST;
      wrap          <= 1'b0;
      ptr           <= '0;
      app_reset_n   <= ~LOAD_RST;
      app_pmem_cen  <= 1'b1;
      app_pmem_wen  <= 2'b11;
      app_pmem_addr <= '0;
      app_pmem_dout <= '0;
    end else begin
      app_reset_n  <= ~load;
      // Strobe is re-evaluated every cycle, so it lasts exactly one cycle per accepted write
      app_pmem_cen <= ~data_wr;
      app_pmem_wen <= data_wr ? ~per_we : 2'b11;

      if (data_wr) begin
        app_pmem_addr <= ptr;
        app_pmem_dout <= per_din;
        ptr           <= ptr + PTR_ONE;
        if (ptr == PTR_MAX) begin
          wrap <= 1'b1;
        end
      end

      if (ptr_wr) begin
        ptr <= per_din[PMEM_AW-1:0];
      end

      if (ctrl_wr) begin
        load <= per_din[CTRL_LOAD_BIT];
        // Only a rising LOAD edge starts a fresh image; re-writing 1 keeps the position
        if (!load && per_din[CTRL_LOAD_BIT]) begin
          ptr  <= '0;
          wrap <= 1'b0;
        end
      end
    end
  end

  // Read mux; zero when not addressed so it can be OR-ed onto the shared bus
  always_comb begin
    per_dout = '0;
    if (rd_en) begin
      if (ctrl_hit) begin
        per_dout[CTRL_LOAD_BIT] = load;
        per_dout[CTRL_WRAP_BIT] = wrap;
      end else if (ptr_hit) begin
        per_dout[PMEM_AW-1:0] = ptr;
      end
    end
  end

endmodule

// File: tb/tb_app_loader_periph.sv
// Purpose : self-checking bench for app_loader_periph (register tables + pmem write scoreboard).
// Latency : checks the pmem strobe in the cycle after each DATA write.
// Backpr. : n/a.
module tb_app_loader_periph;
  import app_loader_pkg::*;

  localparam logic [13:0] A_CTRL = 14'h0054;
  localparam logic [13:0] A_DATA = 14'h0055;
  localparam logic [13:0] A_PTR  = 14'h0056;
  localparam logic [13:0] A_NONE = 14'h0050;

`ifdef APP_LOADER_HOLD_ON_RESET_EN
  localparam logic RST_LOAD = 1'b1;
`else
  localparam logic RST_LOAD = 1'b0;
`endif
  localparam logic [15:0] RST_CTRL = {15'd0, RST_LOAD};

  logic        mclk;
  logic        puc_rst;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic        smclk_en;
  logic [15:0] per_dout;
  logic        app_reset_n;
  logic [12:0] app_pmem_addr;
  logic [15:0] app_pmem_dout;
  logic        app_pmem_cen;
  logic [1:0]  app_pmem_wen;

  app_loader_periph dut (
    .mclk          (mclk),
    .puc_rst       (puc_rst),
    .per_addr      (per_addr),
    .per_din       (per_din),
    .per_en        (per_en),
    .per_we        (per_we),
    .smclk_en      (smclk_en),
    .per_dout      (per_dout),
    .app_reset_n   (app_reset_n),
    .app_pmem_addr (app_pmem_addr),
    .app_pmem_dout (app_pmem_dout),
    .app_pmem_cen  (app_pmem_cen),
    .app_pmem_wen  (app_pmem_wen)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  int tests = 0;
  int fails = 0;
  int n_strobes = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Expected pmem writes, pushed when the DATA write is driven
  typedef struct packed {
    logic [12:0] addr;
    logic [15:0] dat;
    logic [1:0]  wen;
  } wr_t;
  wr_t sb[$];
  wr_t mon_e;

  // Loader model state used only to predict pmem write addresses
  logic        m_load;
  logic [12:0] m_ptr;

  always @(negedge mclk) begin
    if (!puc_rst) begin
      if (!per_en) chk("dout_idle", {16'd0, per_dout}, 32'd0);
      if (app_pmem_cen === 1'b0) begin
        n_strobes++;
        if (sb.size() == 0) begin
          chk("unexpected_strobe", {19'd0, app_pmem_addr}, 32'hFFFF_FFFF);
        end else begin
          mon_e = sb.pop_front();
          chk("pmem_addr", {19'd0, app_pmem_addr}, {19'd0, mon_e.addr});
          chk("pmem_dout", {16'd0, app_pmem_dout}, {16'd0, mon_e.dat});
          chk("pmem_wen",  {30'd0, app_pmem_wen},  {30'd0, mon_e.wen});
        end
      end
    end
  end

  // One bus cycle: drive, optionally compare the combinational read, advance past the edge
  task automatic bus(input string nm, input logic en, input logic [1:0] we,
                     input logic [13:0] a, input logic [15:0] d,
                     input logic do_chk, input logic [15:0] exp);
    per_en   = en;
    per_we   = we;
    per_addr = a;
    per_din  = d;
    smclk_en = 1'($urandom_range(0, 1));
    #1;
    if (do_chk) chk(nm, {16'd0, per_dout}, {16'd0, exp});
    if (en && we != 2'b00) begin
      if (a == A_CTRL && we[0]) begin
        if (!m_load && d[0]) m_ptr = 13'd0;
        m_load = d[0];
      end else if (a == A_DATA && m_load) begin
        sb.push_back('{m_ptr, d, ~we});
        m_ptr = m_ptr + 13'd1;
      end else if (a == A_PTR && m_load) begin
        m_ptr = d[12:0];
      end
    end
    @(posedge mclk);
    #2;
  endtask

  task automatic idle();
    bus("idle", 1'b0, 2'b00, A_NONE, 16'h0000, 1'b0, 16'h0000);
  endtask

  typedef struct {
    string       nm;
    logic        en;
    logic [1:0]  we;
    logic [13:0] a;
    logic [15:0] d;
    logic        c;
    logic [15:0] e;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(string nm, logic en, logic [1:0] we, logic [13:0] a,
                              logic [15:0] d, logic c, logic [15:0] e);
    tbl.push_back('{nm, en, we, a, d, c, e});
  endfunction

  task automatic run_tbl();
    foreach (tbl[i]) bus(tbl[i].nm, tbl[i].en, tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].c, tbl[i].e);
    tbl.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n0;

  initial begin
    puc_rst  = 1'b1;
    per_en   = 1'b0;
    per_we   = 2'b00;
    per_addr = 14'd0;
    per_din  = 16'd0;
    smclk_en = 1'b0;
    m_load   = RST_LOAD;
    m_ptr    = 13'd0;

    #50;
    chk("rst_app_reset_n", {31'd0, app_reset_n}, {31'd0, ~RST_LOAD});
    chk("rst_cen",  {31'd0, app_pmem_cen}, 32'd1);
    chk("rst_wen",  {30'd0, app_pmem_wen}, 32'd3);
    chk("rst_addr", {19'd0, app_pmem_addr}, 32'd0);
    chk("rst_dout", {16'd0, app_pmem_dout}, 32'd0);
    chk("rst_per_dout", {16'd0, per_dout}, 32'd0);
    #40;
    puc_rst = 1'b0;
    @(posedge mclk);
    #2;

    // Reset readback, then enter load mode
    add("rd_ctrl_rst", 1, 2'b00, A_CTRL, 16'h0, 1, RST_CTRL);
    add("rd_ptr_rst",  1, 2'b00, A_PTR,  16'h0, 1, 16'h0000);
    add("rd_data",     1, 2'b00, A_DATA, 16'h0, 1, 16'h0000);
    add("rd_unmapped", 1, 2'b00, A_NONE, 16'h0, 1, 16'h0000);
    add("wr_ctrl_1",   1, 2'b01, A_CTRL, 16'h0001, 0, 16'h0);
    run_tbl();
    chk("rstn_at_ctrl_edge", {31'd0, app_reset_n}, {31'd0, ~RST_LOAD});

    // Basic load
    add("wr_data0", 1, 2'b11, A_DATA, 16'h4DAC, 0, 16'h0);
    add("wr_data1", 1, 2'b11, A_DATA, 16'h73CC, 0, 16'h0);
    run_tbl();
    chk("rstn_loading", {31'd0, app_reset_n}, 32'd0);
    idle();

    // Streaming: 39 back-to-back writes at addr 2..40
    n0 = n_strobes;
    for (int i = 0; i < 39; i++) bus("stream", 1, 2'b11, A_DATA, 16'h73CC, 0, 16'h0);
    add("rd_ptr_stream", 1, 2'b00, A_PTR, 16'h0, 1, 16'h0029);
    run_tbl();
    chk("stream_count", n_strobes - n0, 32'd39);

    // Leave load mode; the very next DATA write must be dropped
    bus("wr_ctrl_0", 1, 2'b01, A_CTRL, 16'h0000, 0, 16'h0);
    chk("rstn_still_held", {31'd0, app_reset_n}, 32'd0);
    bus("wr_data_ignored", 1, 2'b11, A_DATA, 16'h1111, 0, 16'h0);
    chk("rstn_released", {31'd0, app_reset_n}, 32'd1);

    add("wr_ptr_ignored", 1, 2'b11, A_PTR,  16'h0100, 0, 16'h0);
    add("rd_ptr_kept",    1, 2'b00, A_PTR,  16'h0,    1, 16'h0029);
    add("rd_ctrl_idle",   1, 2'b00, A_CTRL, 16'h0,    1, 16'h0000);
    // Wrap
    add("wr_ctrl_1b",     1, 2'b01, A_CTRL, 16'h0001, 0, 16'h0);
    add("rd_ptr_cleared", 1, 2'b00, A_PTR,  16'h0,    1, 16'h0000);
    add("wr_ptr_max",     1, 2'b11, A_PTR,  16'h1FFF, 0, 16'h0);
    add("rd_ptr_max",     1, 2'b00, A_PTR,  16'h0,    1, 16'h1FFF);
    add("wr_data_top",    1, 2'b11, A_DATA, 16'hBEEF, 0, 16'h0);
    add("wr_data_wrap",   1, 2'b11, A_DATA, 16'hCAFE, 0, 16'h0);
    add("rd_ctrl_wrap",   1, 2'b00, A_CTRL, 16'h0,    1, 16'h0101);
    add("rd_ptr_wrapped", 1, 2'b00, A_PTR,  16'h0,    1, 16'h0001);
    // Byte lane
    add("wr_data_hi",     1, 2'b10, A_DATA, 16'hA55A, 0, 16'h0);
    add("rd_ptr_hi",      1, 2'b00, A_PTR,  16'h0,    1, 16'h0002);
    // Re-writing LOAD=1 while loading, and a high-lane-only CTRL write, change nothing
    add("wr_ctrl_again",  1, 2'b01, A_CTRL, 16'h0001, 0, 16'h0);
    add("wr_ctrl_hilane", 1, 2'b10, A_CTRL, 16'h0000, 0, 16'h0);
    add("rd_ctrl_kept",   1, 2'b00, A_CTRL, 16'h0,    1, 16'h0101);
    add("rd_ptr_kept2",   1, 2'b00, A_PTR,  16'h0,    1, 16'h0002);
    add("rd_ctrl_noen",   0, 2'b00, A_CTRL, 16'h0,    1, 16'h0000);
    add("wr_unmapped",    1, 2'b11, A_NONE, 16'hFFFF, 0, 16'h0);
    add("rd_unmapped2",   1, 2'b00, A_NONE, 16'h0,    1, 16'h0000);
    // 0 then 1 restarts the image
    add("wr_ctrl_0b",     1, 2'b01, A_CTRL, 16'h0000, 0, 16'h0);
    add("wr_ctrl_1c",     1, 2'b01, A_CTRL, 16'h0001, 0, 16'h0);
    add("rd_ctrl_fresh",  1, 2'b00, A_CTRL, 16'h0,    1, 16'h0001);
    add("rd_ptr_fresh",   1, 2'b00, A_PTR,  16'h0,    1, 16'h0000);
    run_tbl();

    // Reset in the middle of a stream
    for (int i = 0; i < 5; i++) bus("stream2", 1, 2'b11, A_DATA, 16'h1234, 0, 16'h0);
    per_en = 1'b0;
    per_we = 2'b00;
    #1;
    puc_rst = 1'b1;
    #1;
    chk("midrst_cen",  {31'd0, app_pmem_cen}, 32'd1);
    chk("midrst_wen",  {30'd0, app_pmem_wen}, 32'd3);
    chk("midrst_addr", {19'd0, app_pmem_addr}, 32'd0);
    chk("midrst_rstn", {31'd0, app_reset_n}, {31'd0, ~RST_LOAD});
    sb.delete();
    m_load = RST_LOAD;
    m_ptr  = 13'd0;
    @(posedge mclk);
    #2;
    puc_rst = 1'b0;
    add("rd_ptr_midrst",  1, 2'b00, A_PTR,  16'h0, 1, 16'h0000);
    add("rd_ctrl_midrst", 1, 2'b00, A_CTRL, 16'h0, 1, RST_CTRL);
    add("wr_data_postrst", 1, 2'b11, A_DATA, 16'h5A5A, 0, 16'h0);
    run_tbl();

    idle();
    idle();
    idle();
    chk("sb_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/app_loader_periph.md
# app_loader_periph

Memory-mapped openMSP430 peripheral that lets the host CPU load a program image into a second (application) core's program memory. The host holds the application core in reset, streams 16-bit words through a data register into an auto-incrementing pmem write port, then releases the application reset. It sits on the host's peripheral bus (per_*) and drives the application pmem write port and the application reset.

## Interface
- BASE_ADDR, 14'h0054, word address of CTRL; DATA = BASE_ADDR+1, PTR = BASE_ADDR+2.
- PMEM_AW, 13, application pmem word-address width.
- mclk  in  1  host clock; all state on rising edge.
- puc_rst  in  1  asynchronous, active-high reset.
- per_addr  in  14  peripheral word address.
- per_din  in  16  write data.
- per_en  in  1  bus access strobe.
- per_we  in  2  byte-lane write enables; 00 = read.
- smclk_en  in  1  reserved, ignored.
- per_dout  out  16  read data; 0 when not addressed, so it can be OR-ed onto the bus.
- app_reset_n  out  1  application core reset, active low.
- app_pmem_addr  out  PMEM_AW  pmem word address.
- app_pmem_dout  out  16  pmem write data.
- app_pmem_cen  out  1  pmem chip enable, active low.
- app_pmem_wen  out  2  pmem byte write enables, active low.

## Operation
- CTRL register, fields:
  - bit0 LOAD (R/W via per_we[0]): 1 = load mode, holds the application core in reset.
  - bit8 WRAP (RO, sticky): the pointer wrapped.
  - Other bits read 0.
- A LOAD write of 0 then 1 clears the pointer to 0 and clears WRAP. Writing 1 while LOAD is already 1 changes nothing.
- DATA write with per_en=1, per_we≠00, address DATA, LOAD=1:
  - Issues one pmem write at the current pointer, with app_pmem_wen = ~per_we.
  - Then increments the pointer.
  - Incrementing from 2^PMEM_AW−1 wraps to 0 and sets WRAP.
- DATA writes with LOAD=0 are ignored: no strobe, no pointer change. DATA reads return 0.
- PTR register (R/W): reads the pointer, zero-extended. Writes load per_din[PMEM_AW-1:0] only when LOAD=1; writes are ignored otherwise.
- Reads: when per_en=1, per_we=00 and the address hits a register, per_dout = register value; otherwise 0. per_dout is combinational.
- app_reset_n = ~LOAD, registered.
- smclk_en has no effect.

## Timing
- Reset values:
  - LOAD = 0, so app_reset_n = 1 (see Configuration for the alternative).
  - Pointer 0, WRAP 0.
  - app_pmem_cen = 1, app_pmem_wen = 2'b11, app_pmem_addr = 0, app_pmem_dout = 0.
- A DATA write sampled at edge N drives the pmem strobe (cen=0, wen, addr, dout) for exactly the cycle after edge N. At edge N+1 the outputs return to cen=1 and wen=11, unless another write is sampled.
- per_en held with DATA address and per_we=11 for K cycles produces K writes to consecutive addresses, one per cycle, with no gaps.
- app_reset_n changes one cycle after the CTRL write edge.
- puc_rst asserted mid-load aborts immediately (asynchronously): the strobe deasserts and all state returns to reset values.
- Writing LOAD=0 takes effect at the write edge. A DATA write in the following cycle is ignored.

## Configuration
- APP_LOADER_HOLD_ON_RESET_EN:
  - Defined: LOAD resets to 1, so the application is held in reset (app_reset_n = 0) from puc_rst until the host writes LOAD=0. The pointer is 0 and ready for loading.
  - Undefined: LOAD resets to 0 and the application runs out of reset.

## Structure
- Package app_loader_pkg holds:
  - Register word offsets (CTRL 0, DATA 1, PTR 2).
  - CTRL bit positions (LOAD 0, WRAP 8).
  - Default PMEM_AW.
- Single module, no sub-modules. The address decode, register file, pointer and pmem strobe register are all inline.

## Test plan
- Basic load: reset 90 ns, write CTRL=0x0001 (per_we=01), then write DATA=0x4DAC and DATA=0x73CC (per_we=11). Required: app_reset_n=0; pmem writes addr 0 / 0x4DAC, then addr 1 / 0x73CC; wen=00, cen=0 one cycle each.
- Streaming: hold the DATA write (0x73CC, per_we=11) for 39 cycles -> 39 consecutive pmem writes at addr 2..40. Then write CTRL=0x0000 -> app_reset_n=1 next cycle, and further DATA writes produce no strobe.
- Wrap: set LOAD, write PTR=0x1FFF, write DATA twice -> writes at 0x1FFF then 0x0000. CTRL reads 0x0101.
- Byte lane: DATA write with per_we=10 -> app_pmem_wen=01; the pointer still increments.
- Readback/bus: read CTRL, PTR and an unmapped address -> correct values, and 0 for the unmapped address. per_dout=0 whenever per_en=0.
- Reset mid-load: assert puc_rst during streaming -> cen=1 immediately, pointer 0, app_reset_n equals its configured reset value.
